bcd_bin: RTL and testbench

BCD_BIN -- requirements
Module: bcd_bin

---
 rtl/bcd_bin.sv | 51 +++++
 tb/tb_bcd_bin.sv | 124 ++++++++++++
 2 files changed

// File: rtl/bcd_bin.sv
// bcd_bin: registered two-digit BCD (0..19) to 4-bit binary converter with error flags
// clk        : clock, rising edge
// rst_n      : asynchronous active-low reset
// in_valid   : b carries a conversion request this cycle
// b          : b[4] tens digit, b[3:0] units digit
// y          : binary result of the last request
// out_valid  : y/err flags were updated by the previous cycle's request
// err_digit  : last request had a units digit above 9
// err_range  : last request was legal BCD but 16..19
// err_sticky : any error registered since reset
module bcd_bin #(
    parameter bit SATURATE = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [4:0] b,
    output logic [3:0] y,
    output logic       out_valid,
    output logic       err_digit,
    output logic       err_range,
    output logic       err_sticky
);
    logic [4:0] val;
    logic       bad_digit;
    logic       over;
    logic [3:0] y_next;
    always_comb begin
        val       = {1'b0, b[3:0]} + (b[4] ? 5'd10 : 5'd0);
        bad_digit = b[3:0] > 4'd9;
        over      = !bad_digit && val > 5'd15;
        y_next    = bad_digit ? 4'd0 : over ? (SATURATE ? 4'd15 : 4'd0) : val[3:0];
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y          <= 4'd0;
            out_valid  <= 1'b0;
            err_digit  <= 1'b0;
            err_range  <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                y          <= y_next;
                err_digit  <= bad_digit;
                err_range  <= over;
                err_sticky <= err_sticky | bad_digit | over;
            end
        end
    end
endmodule

// File: tb/tb_bcd_bin.sv
// tb_bcd_bin: directed checks of bcd_bin with SATURATE=0 and SATURATE=1 side by side
module tb_bcd_bin;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [4:0] b;
    logic [3:0] y0, y1;
    logic       ov0, ov1, ed0, ed1, er0, er1, es0, es1;
    int         tests = 0;
    int         fails = 0;

    bcd_bin #(.SATURATE(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .b(b),
        .y(y0), .out_valid(ov0), .err_digit(ed0), .err_range(er0), .err_sticky(es0)
    );
    bcd_bin #(.SATURATE(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .b(b),
        .y(y1), .out_valid(ov1), .err_digit(ed1), .err_range(er1), .err_sticky(es1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic [4:0] code);
        in_valid = v;
        b        = code;
        @(posedge clk);
        #1;
    endtask

    // Checks y and both per-request flags on both instances.
    task automatic chk_res(input string tag, input int ey0, input int ey1, input logic ed, input logic er);
        chk({tag, " y0"}, {4'd0, y0}, ey0[7:0]);
        chk({tag, " y1"}, {4'd0, y1}, ey1[7:0]);
        chk({tag, " ed"}, {6'd0, ed0, ed1}, {6'd0, ed, ed});
        chk({tag, " er"}, {6'd0, er0, er1}, {6'd0, er, er});
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " y"}, {y0, y1}, 8'h00);
        chk({tag, " flags"}, {ov0, ov1, ed0, ed1, er0, er1, es0, es1}, 8'h00);
    endtask

    logic [4:0] legal_codes [6] = '{5'h00, 5'h01, 5'h11, 5'h15, 5'h10, 5'h08};
    int         legal_y     [6] = '{0, 1, 11, 15, 10, 8};

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        b        = 5'h00;
        #1;
        chk_zero("reset");
        #1 rst_n = 1'b1;
        #1;
        chk_zero("post_release");

        for (int i = 0; i < 6; i++) begin
            step(1'b1, legal_codes[i]);
            chk("legal ov", {6'd0, ov0, ov1}, 8'h03);
            chk_res("legal", legal_y[i], legal_y[i], 1'b0, 1'b0);
        end
        chk("legal sticky", {6'd0, es0, es1}, 8'h00);

        step(1'b1, 5'h0C);
        chk_res("digit_0C", 0, 0, 1'b1, 1'b0);
        chk("digit_0C sticky", {6'd0, es0, es1}, 8'h03);
        step(1'b1, 5'h1F);
        chk_res("digit_1F", 0, 0, 1'b1, 1'b0);
        step(1'b1, 5'h1A);
        chk_res("digit_1A", 0, 0, 1'b1, 1'b0);

        step(1'b1, 5'h16);
        chk_res("range_16", 0, 15, 1'b0, 1'b1);
        step(1'b1, 5'h19);
        chk_res("range_19", 0, 15, 1'b0, 1'b1);

        step(1'b1, 5'h13);
        chk("hold ov", {6'd0, ov0, ov1}, 8'h03);
        chk_res("hold_13", 13, 13, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 5'h0E);
            chk("idle ov", {6'd0, ov0, ov1}, 8'h00);
            chk_res("idle", 13, 13, 1'b0, 1'b0);
        end
        chk("idle sticky", {6'd0, es0, es1}, 8'h03);

        step(1'b1, 5'h0C);
        chk("pre_rst ed", {6'd0, ed0, ed1}, 8'h03);
        #2 rst_n = 1'b0;
        #1;
        chk_zero("async_rst");

        in_valid = 1'b1;
        b        = 5'h05;
        @(posedge clk);
        #1;
        chk_zero("rst_with_req");
        rst_n = 1'b1;
        step(1'b0, 5'h05);
        chk_zero("no_ghost");

        for (int i = 0; i < 32; i++) begin
            automatic logic [4:0] c = i[4:0];
            automatic int u   = i % 16;
            automatic int v   = (i / 16) * 10 + u;
            automatic logic dg = u > 9;
            automatic logic rg = !dg && v > 15;
            step(1'b1, c);
            chk("exh ov", {6'd0, ov0, ov1}, 8'h03);
            chk_res($sformatf("exh_%02h", c), (dg || rg) ? 0 : v, dg ? 0 : rg ? 15 : v, dg, rg);
        end
        chk("exh sticky", {6'd0, es0, es1}, 8'h03);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
